// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, glitch rejection and framing-error report
module uart_rx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   // Full-bit and half-bit sample points; the half point centres sampling in each bit cell.
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {
      WAIT_IDLE = 3'd0,
      IDLE      = 3'd1,
      START     = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4,
      CLEANUP   = 3'd5
   } state_t;

   state_t      state, state_next;
   logic        sync1, rx_s;
   logic [15:0] count, count_next;
   logic [2:0]  index, index_next;
   logic [7:0]  shift, shift_next;
   logic [7:0]  rx_byte, rx_byte_next;
   logic        dv, dv_next;
   logic        err, err_next;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= i_Rx_Serial;
         rx_s  <= sync1;
      end
   end

   // State and datapath registers.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state   <= WAIT_IDLE;
         count   <= 16'd0;
         index   <= 3'd0;
         shift   <= 8'h00;
         rx_byte <= 8'h00;
         dv      <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_next;
         count   <= count_next;
         index   <= index_next;
         shift   <= shift_next;
         rx_byte <= rx_byte_next;
         dv      <= dv_next;
         err     <= err_next;
      end
   end

   // Next-state and datapath decisions; a held-low line after a framing error must go high before re-arming.
   always_comb begin
      state_next   = state;
      count_next   = count;
      index_next   = index;
      shift_next   = shift;
      rx_byte_next = rx_byte;
      dv_next      = 1'b0;
      err_next     = 1'b0;
      case (state)
         WAIT_IDLE: begin
            if (rx_s) state_next = IDLE;
         end
         IDLE: begin
            count_next = 16'd0;
            index_next = 3'd0;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (count == HALF) begin
               count_next = 16'd0;
               state_next = rx_s ? IDLE : DATA;
            end else begin
               count_next = count + 16'd1;
            end
         end
         DATA: begin
            if (count == LAST) begin
               count_next        = 16'd0;
               shift_next[index] = rx_s;
               index_next        = index + 3'd1;
               if (index == 3'd7) state_next = STOP;
            end else begin
               count_next = count + 16'd1;
            end
         end
         STOP: begin
            if (count == LAST) begin
               count_next = 16'd0;
               state_next = CLEANUP;
               if (rx_s) begin
                  rx_byte_next = shift;
                  dv_next      = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
            end else begin
               count_next = count + 16'd1;
            end
         end
         CLEANUP: begin
            state_next = err ? WAIT_IDLE : IDLE;
         end
         default: begin
            state_next = WAIT_IDLE;
         end
      endcase
   end

   assign o_Rx_DV        = dv;
   assign o_Rx_Byte      = rx_byte;
   assign o_Rx_Frame_Err = err;
   assign o_Rx_Active    = (state == START) || (state == DATA) || (state == STOP);

endmodule
